// File: rtl/acc_req_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : acc_req_buffer
//  Description : Request queue and outstanding-transaction tracker that sits
//                between an accelerator dispatcher and the accelerator.
//                Requests are buffered in a registered FIFO (no fall-through)
//                and issued in order. Issue stops while MAX_OUTSTANDING
//                requests are unanswered. Responses pass straight through
//                combinationally and retire outstanding requests.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH            request queue entries (power of two, >= 2)
//    MAX_OUTSTANDING  issued-but-unanswered limit (>= 1)
//  Ports
//    clk_i               clock, all state on the rising edge
//    rst_i               asynchronous active-high reset
//    disp_req_i/_valid_i/_ready_o     dispatcher -> queue request handshake
//    acc_req_o/_valid_o/_ready_i      queue head -> accelerator handshake
//    acc_resp_i/_valid_i/_ready_o     accelerator response handshake
//    disp_resp_o/_valid_o/_ready_i    response toward the dispatcher
//    outstanding_o       issued-but-unanswered count
//    idle_o              queue empty and nothing outstanding
//    order_err_o         sticky out-of-order response flag
//  Build option
//    ACC_REQ_BUFFER_ORDER_CHECK_EN  when defined, builds a trans_id tracker
//                                   and drives order_err_o; otherwise
//                                   order_err_o is tied low.
// ============================================================================

package acc_req_buffer_pkg;
  typedef logic [3:0] trans_id_t;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] rs1;
    trans_id_t   trans_id;
    logic        store_pending;
  } accelerator_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
    trans_id_t   trans_id;
  } accelerator_resp_t;
endpackage

module acc_req_buffer
  import acc_req_buffer_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  accelerator_req_t                     disp_req_i,
  input  logic                                 disp_req_valid_i,
  output logic                                 disp_req_ready_o,
  output accelerator_req_t                     acc_req_o,
  output logic                                 acc_req_valid_o,
  input  logic                                 acc_req_ready_i,
  input  accelerator_resp_t                    acc_resp_i,
  input  logic                                 acc_resp_valid_i,
  output logic                                 acc_resp_ready_o,
  output accelerator_resp_t                    disp_resp_o,
  output logic                                 disp_resp_valid_o,
  input  logic                                 disp_resp_ready_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 idle_o,
  output logic                                 order_err_o
);

  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;
  localparam int c_out_w  = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
  localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);

  // --------------------------------------------------------------------------
  // Request queue
  // --------------------------------------------------------------------------
  accelerator_req_t    r_mem [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_out_w-1:0]  r_outstanding;

  logic w_push;
  logic w_issue;
  logic w_resp_fire;
  logic w_not_empty;
  logic w_can_issue;

  // Ready looks only at the occupancy so the dispatcher never sees a
  // combinational path from the accelerator's ready.
  assign disp_req_ready_o = (r_count < c_depth);
  assign w_push           = disp_req_valid_i && disp_req_ready_o;

  assign w_not_empty     = (r_count != '0);
  assign w_can_issue     = (r_outstanding < c_max_out);
  assign acc_req_valid_o = w_not_empty && w_can_issue;
  assign acc_req_o       = r_mem[r_rd_ptr];
  assign w_issue         = acc_req_valid_o && acc_req_ready_i;

  // Storage is data only; validity is carried by r_count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= disp_req_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Response path and outstanding counter
  // --------------------------------------------------------------------------
  assign disp_resp_o       = acc_resp_i;
  assign disp_resp_valid_o = acc_resp_valid_i;
  assign acc_resp_ready_o  = disp_resp_ready_i;
  assign w_resp_fire       = acc_resp_valid_i && disp_resp_ready_i;

  // An issue can only happen below the limit, so the increment never
  // overflows. A response with nothing outstanding is absorbed silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else if (w_issue && !w_resp_fire) begin
      r_outstanding <= r_outstanding + c_out_w'(1);
    end else if (w_resp_fire && !w_issue && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - c_out_w'(1);
    end
  end

  assign outstanding_o = r_outstanding;
  assign idle_o        = !w_not_empty && (r_outstanding == '0);

  // --------------------------------------------------------------------------
  // In-order response checking
  // --------------------------------------------------------------------------
`ifdef ACC_REQ_BUFFER_ORDER_CHECK_EN
  localparam int c_trk_aw = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [c_trk_aw-1:0] c_trk_last = c_trk_aw'(MAX_OUTSTANDING - 1);

  trans_id_t           r_trk_mem [MAX_OUTSTANDING];
  logic [c_trk_aw-1:0] r_trk_wr;
  logic [c_trk_aw-1:0] r_trk_rd;
  logic [c_out_w-1:0]  r_trk_cnt;
  logic                r_order_err;

  logic w_trk_empty;
  logic w_trk_full;
  logic w_trk_push;
  logic w_trk_pop;
  logic w_mismatch;

  // MAX_OUTSTANDING need not be a power of two, so wrap explicitly.
  function automatic logic [c_trk_aw-1:0] trk_next(input logic [c_trk_aw-1:0] p);
    return (p == c_trk_last) ? '0 : p + 1'b1;
  endfunction

  assign w_trk_empty = (r_trk_cnt == '0);
  assign w_trk_full  = (r_trk_cnt == c_max_out);
  assign w_trk_pop   = w_resp_fire && !w_trk_empty;
  // A stray response that coincides with an issue at zero outstanding can
  // leave the tracker one ahead of the counter; never write past capacity.
  assign w_trk_push  = w_issue && (!w_trk_full || w_trk_pop);
  assign w_mismatch  = w_resp_fire &&
                       (w_trk_empty || (r_trk_mem[r_trk_rd] != acc_resp_i.trans_id));

  always_ff @(posedge clk_i) begin
    if (w_trk_push) begin
      r_trk_mem[r_trk_wr] <= acc_req_o.trans_id;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_trk_wr    <= '0;
      r_trk_rd    <= '0;
      r_trk_cnt   <= '0;
      r_order_err <= 1'b0;
    end else begin
      if (w_trk_push) begin
        r_trk_wr <= trk_next(r_trk_wr);
      end
      if (w_trk_pop) begin
        r_trk_rd <= trk_next(r_trk_rd);
      end
      case ({w_trk_push, w_trk_pop})
        2'b10:   r_trk_cnt <= r_trk_cnt + c_out_w'(1);
        2'b01:   r_trk_cnt <= r_trk_cnt - c_out_w'(1);
        default: r_trk_cnt <= r_trk_cnt;
      endcase
      // Sticky until reset.
      if (w_mismatch) begin
        r_order_err <= 1'b1;
      end
    end
  end

  assign order_err_o = r_order_err;
`else
  assign order_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_acc_req_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_req_buffer
//  Description : Self-checking bench for acc_req_buffer (DEPTH=4,
//                MAX_OUTSTANDING=2) against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_req_buffer;
  import acc_req_buffer_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int OW      = $clog2(MAX_OUT + 1);

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  accelerator_req_t  disp_req_i;
  logic              disp_req_valid_i;
  logic              disp_req_ready_o;
  accelerator_req_t  acc_req_o;
  logic              acc_req_valid_o;
  logic              acc_req_ready_i;
  accelerator_resp_t acc_resp_i;
  logic              acc_resp_valid_i;
  logic              acc_resp_ready_o;
  accelerator_resp_t disp_resp_o;
  logic              disp_resp_valid_o;
  logic              disp_resp_ready_i;
  logic [OW-1:0]     outstanding_o;
  logic              idle_o;
  logic              order_err_o;

  acc_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .disp_req_i(disp_req_i), .disp_req_valid_i(disp_req_valid_i), .disp_req_ready_o(disp_req_ready_o),
    .acc_req_o(acc_req_o), .acc_req_valid_o(acc_req_valid_o), .acc_req_ready_i(acc_req_ready_i),
    .acc_resp_i(acc_resp_i), .acc_resp_valid_i(acc_resp_valid_i), .acc_resp_ready_o(acc_resp_ready_o),
    .disp_resp_o(disp_resp_o), .disp_resp_valid_o(disp_resp_valid_o), .disp_resp_ready_i(disp_resp_ready_i),
    .outstanding_o(outstanding_o), .idle_o(idle_o), .order_err_o(order_err_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef ACC_REQ_BUFFER_ORDER_CHECK_EN
  localparam bit ORDER_CHECK = 1'b1;
`else
  localparam bit ORDER_CHECK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: queued requests, issued ids awaiting answer, counters.
  accelerator_req_t m_q[$];
  trans_id_t        m_trk[$];
  trans_id_t        m_pushed[$];
  int               m_out;
  bit               m_err;

  function automatic accelerator_req_t mk_req(input trans_id_t id);
    accelerator_req_t r;
    r.insn          = $urandom;
    r.rs1           = $urandom;
    r.trans_id      = id;
    r.store_pending = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic accelerator_resp_t mk_resp(input trans_id_t id);
    accelerator_resp_t r;
    r.data     = $urandom;
    r.error    = 1'($urandom_range(0, 1));
    r.trans_id = id;
    return r;
  endfunction

  task automatic idle_inputs();
    disp_req_i        = '0;
    disp_req_valid_i  = 1'b0;
    acc_req_ready_i   = 1'b0;
    acc_resp_i        = '0;
    acc_resp_valid_i  = 1'b0;
    disp_resp_ready_i = 1'b1;
  endtask

  task automatic model_clear();
    m_q.delete();
    m_trk.delete();
    m_pushed.delete();
    m_out = 0;
    m_err = 1'b0;
  endtask

  // Advance the model by the handshakes visible right now, then clock.
  task automatic tick();
    bit push, issue, resp;
    push  = disp_req_valid_i && (m_q.size() < DEPTH);
    issue = (m_q.size() > 0) && (m_out < MAX_OUT) && acc_req_ready_i;
    resp  = acc_resp_valid_i && disp_resp_ready_i;
    if (ORDER_CHECK && resp && (m_trk.size() == 0 || m_trk[0] != acc_resp_i.trans_id))
      m_err = 1'b1;
    if (resp && m_trk.size() > 0) void'(m_trk.pop_front());
    if (issue) begin
      m_trk.push_back(m_q[0].trans_id);
      void'(m_q.pop_front());
    end
    if (push) begin
      m_q.push_back(disp_req_i);
      m_pushed.push_back(disp_req_i.trans_id);
    end
    if (issue && !resp) m_out++;
    else if (resp && !issue && m_out > 0) m_out--;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst_i = 1'b1;
    #2;
    total += 5;
    if (disp_req_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", disp_req_ready_o); end
    if (acc_req_valid_o !== 1'b0)  begin bad++; $display("FAIL rst_valid: got %b want 0", acc_req_valid_o); end
    if (outstanding_o !== '0)      begin bad++; $display("FAIL rst_out: got %0d want 0", outstanding_o); end
    if (idle_o !== 1'b1)           begin bad++; $display("FAIL rst_idle: got %b want 1", idle_o); end
    if (order_err_o !== 1'b0)      begin bad++; $display("FAIL rst_err: got %b want 0", order_err_o); end
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
    @(negedge clk_i);
    total += 5;
    if (disp_req_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", disp_req_ready_o); end
    if (acc_req_valid_o !== 1'b0)  begin bad++; $display("FAIL post_rst_valid: got %b want 0", acc_req_valid_o); end
    if (outstanding_o !== '0)      begin bad++; $display("FAIL post_rst_out: got %0d want 0", outstanding_o); end
    if (idle_o !== 1'b1)           begin bad++; $display("FAIL post_rst_idle: got %b want 1", idle_o); end
    if (order_err_o !== 1'b0)      begin bad++; $display("FAIL post_rst_err: got %b want 0", order_err_o); end
    tick();
  endtask

  task automatic test_single_issue();
    disp_req_i = mk_req(4'd3);
    disp_req_valid_i = 1'b1;
    acc_req_ready_i  = 1'b1;
    @(negedge clk_i);
    total += 2;
    if (disp_req_ready_o !== 1'b1) begin bad++; $display("FAIL c0_ready: got %b want 1", disp_req_ready_o); end
    if (acc_req_valid_o !== 1'b0)  begin bad++; $display("FAIL c0_no_fallthrough: got %b want 0", acc_req_valid_o); end
    tick();
    disp_req_valid_i = 1'b0;
    @(negedge clk_i);
    total += 4;
    if (acc_req_valid_o !== 1'b1)      begin bad++; $display("FAIL c1_valid: got %b want 1", acc_req_valid_o); end
    if (acc_req_o.trans_id !== 4'd3)   begin bad++; $display("FAIL c1_id: got %0d want 3", acc_req_o.trans_id); end
    if (acc_req_o !== m_q[0])          begin bad++; $display("FAIL c1_req: got %h want %h", acc_req_o, m_q[0]); end
    if (idle_o !== 1'b0)               begin bad++; $display("FAIL c1_idle: got %b want 0", idle_o); end
    tick();
    acc_req_ready_i   = 1'b0;
    acc_resp_i        = mk_resp(4'd3);
    acc_resp_valid_i  = 1'b1;
    disp_resp_ready_i = 1'b1;
    @(negedge clk_i);
    total += 5;
    if (outstanding_o !== OW'(1))     begin bad++; $display("FAIL c2_out: got %0d want 1", outstanding_o); end
    if (idle_o !== 1'b0)              begin bad++; $display("FAIL c2_idle: got %b want 0", idle_o); end
    if (disp_resp_o !== acc_resp_i)   begin bad++; $display("FAIL resp_data: got %h want %h", disp_resp_o, acc_resp_i); end
    if (disp_resp_valid_o !== 1'b1)   begin bad++; $display("FAIL resp_valid: got %b want 1", disp_resp_valid_o); end
    if (acc_resp_ready_o !== 1'b1)    begin bad++; $display("FAIL resp_ready: got %b want 1", acc_resp_ready_o); end
    tick();
    acc_resp_valid_i  = 1'b0;
    disp_resp_ready_i = 1'b0;
    @(negedge clk_i);
    total += 4;
    if (outstanding_o !== OW'(0))     begin bad++; $display("FAIL c3_out: got %0d want 0", outstanding_o); end
    if (idle_o !== 1'b1)              begin bad++; $display("FAIL c3_idle: got %b want 1", idle_o); end
    if (acc_resp_ready_o !== 1'b0)    begin bad++; $display("FAIL resp_ready_low: got %b want 0", acc_resp_ready_o); end
    if (order_err_o !== m_err)        begin bad++; $display("FAIL c3_err: got %b want %b", order_err_o, m_err); end
    disp_resp_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_full();
    acc_req_ready_i = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      disp_req_i = mk_req(trans_id_t'(i));
      disp_req_valid_i = 1'b1;
      @(negedge clk_i);
      total++;
      if (disp_req_ready_o !== 1'b1) begin bad++; $display("FAIL fill_ready[%0d]: got %b want 1", i, disp_req_ready_o); end
      tick();
    end
    disp_req_i = mk_req(4'd5);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      total += 4;
      if (disp_req_ready_o !== 1'b0)   begin bad++; $display("FAIL full_ready[%0d]: got %b want 0", k, disp_req_ready_o); end
      if (acc_req_valid_o !== 1'b1)    begin bad++; $display("FAIL full_valid[%0d]: got %b want 1", k, acc_req_valid_o); end
      if (acc_req_o.trans_id !== 4'd1) begin bad++; $display("FAIL full_head_id[%0d]: got %0d want 1", k, acc_req_o.trans_id); end
      if (acc_req_o !== m_q[0])        begin bad++; $display("FAIL full_head[%0d]: got %h want %h", k, acc_req_o, m_q[0]); end
      tick();
    end
  endtask

  // Continues from a full queue {1,2,3,4} with id 5 waiting at the input.
  task automatic test_outstanding_limit();
    acc_req_ready_i = 1'b1;
    @(negedge clk_i);
    tick();
    @(negedge clk_i);
    total++;
    if (disp_req_ready_o !== 1'b1) begin bad++; $display("FAIL lim_ready: got %b want 1", disp_req_ready_o); end
    tick();
    disp_req_valid_i = 1'b0;
    @(negedge clk_i);
    total += 4;
    if (acc_req_valid_o !== 1'b0)    begin bad++; $display("FAIL lim_valid: got %b want 0", acc_req_valid_o); end
    if (outstanding_o !== OW'(2))    begin bad++; $display("FAIL lim_out: got %0d want 2", outstanding_o); end
    if (acc_req_o.trans_id !== 4'd3) begin bad++; $display("FAIL lim_head: got %0d want 3", acc_req_o.trans_id); end
    if (m_q.size() != 3)             begin bad++; $display("FAIL lim_model_depth: got %0d want 3", m_q.size()); end
    tick();
  endtask

  // Entered with 3 queued and 2 outstanding.
  task automatic test_reset_mid();
    #3 rst_i = 1'b1;
    #1;
    total += 5;
    if (disp_req_ready_o !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got %b want 1", disp_req_ready_o); end
    if (acc_req_valid_o !== 1'b0)  begin bad++; $display("FAIL mid_rst_valid: got %b want 0", acc_req_valid_o); end
    if (outstanding_o !== '0)      begin bad++; $display("FAIL mid_rst_out: got %0d want 0", outstanding_o); end
    if (idle_o !== 1'b1)           begin bad++; $display("FAIL mid_rst_idle: got %b want 1", idle_o); end
    if (order_err_o !== 1'b0)      begin bad++; $display("FAIL mid_rst_err: got %b want 0", order_err_o); end
    idle_inputs();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_clear();
    acc_resp_i       = mk_resp(4'd1);
    acc_resp_valid_i = 1'b1;
    @(negedge clk_i);
    tick();
    acc_resp_valid_i = 1'b0;
    @(negedge clk_i);
    total += 3;
    if (outstanding_o !== OW'(0)) begin bad++; $display("FAIL late_resp_out: got %0d want 0", outstanding_o); end
    if (idle_o !== 1'b1)          begin bad++; $display("FAIL late_resp_idle: got %b want 1", idle_o); end
    if (order_err_o !== m_err)    begin bad++; $display("FAIL late_resp_err: got %b want %b", order_err_o, m_err); end
    tick();
  endtask

  task automatic test_concurrent();
    do_reset();
    acc_req_ready_i  = 1'b1;
    disp_req_i       = mk_req(4'd7);
    disp_req_valid_i = 1'b1;
    @(negedge clk_i); tick();
    disp_req_i = mk_req(4'd8);
    @(negedge clk_i); tick();
    disp_req_valid_i = 1'b0;
    acc_resp_i       = mk_resp(4'd7);
    acc_resp_valid_i = 1'b1;
    @(negedge clk_i);
    total += 3;
    if (acc_req_valid_o !== 1'b1)    begin bad++; $display("FAIL cc_valid: got %b want 1", acc_req_valid_o); end
    if (acc_req_o.trans_id !== 4'd8) begin bad++; $display("FAIL cc_id: got %0d want 8", acc_req_o.trans_id); end
    if (outstanding_o !== OW'(1))    begin bad++; $display("FAIL cc_out_before: got %0d want 1", outstanding_o); end
    tick();
    acc_resp_i = mk_resp(4'd8);
    @(negedge clk_i);
    total += 2;
    if (outstanding_o !== OW'(1)) begin bad++; $display("FAIL cc_out_same: got %0d want 1", outstanding_o); end
    if (outstanding_o !== OW'(m_out)) begin bad++; $display("FAIL cc_out_model: got %0d want %0d", outstanding_o, m_out); end
    tick();
    acc_resp_valid_i = 1'b0;
    @(negedge clk_i);
    total += 3;
    if (outstanding_o !== OW'(0)) begin bad++; $display("FAIL cc_out_end: got %0d want 0", outstanding_o); end
    if (idle_o !== 1'b1)          begin bad++; $display("FAIL cc_idle: got %b want 1", idle_o); end
    if (order_err_o !== 1'b0)     begin bad++; $display("FAIL cc_err: got %b want 0", order_err_o); end
    tick();
  endtask

  task automatic test_order();
    do_reset();
    acc_req_ready_i  = 1'b1;
    disp_req_i       = mk_req(4'd5);
    disp_req_valid_i = 1'b1;
    @(negedge clk_i); tick();
    disp_req_i = mk_req(4'd6);
    @(negedge clk_i); tick();
    disp_req_valid_i = 1'b0;
    @(negedge clk_i); tick();
    acc_resp_i       = mk_resp(4'd6);
    acc_resp_valid_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (order_err_o !== 1'b0) begin bad++; $display("FAIL ord_before: got %b want 0", order_err_o); end
    tick();
    acc_resp_i = mk_resp(4'd5);
    @(negedge clk_i);
    total += 2;
    if (order_err_o !== ORDER_CHECK) begin bad++; $display("FAIL ord_set: got %b want %b", order_err_o, ORDER_CHECK); end
    if (order_err_o !== m_err)       begin bad++; $display("FAIL ord_model: got %b want %b", order_err_o, m_err); end
    tick();
    acc_resp_valid_i = 1'b0;
    @(negedge clk_i); tick();
    @(negedge clk_i);
    total += 2;
    if (order_err_o !== ORDER_CHECK) begin bad++; $display("FAIL ord_hold: got %b want %b", order_err_o, ORDER_CHECK); end
    if (outstanding_o !== OW'(0))    begin bad++; $display("FAIL ord_out: got %0d want 0", outstanding_o); end
    tick();
  endtask

  task automatic test_stream();
    trans_id_t obs[$];
    int  next_id = 0;
    bool_done: begin end
    do_reset();
    disp_req_i = mk_req(4'd0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (m_pushed.size() == 10 && m_q.size() == 0 && m_out == 0) break;
      if (m_pushed.size() != next_id) begin
        next_id = m_pushed.size();
        disp_req_i = mk_req(trans_id_t'(next_id));
      end
      disp_req_valid_i  = (next_id < 10) && ($urandom_range(0, 3) != 0);
      acc_req_ready_i   = 1'($urandom_range(0, 1));
      disp_resp_ready_i = 1'($urandom_range(0, 1));
      acc_resp_valid_i  = (m_trk.size() > 0) && ($urandom_range(0, 1) == 1);
      acc_resp_i        = mk_resp((m_trk.size() > 0) ? m_trk[0] : 4'd0);
      @(negedge clk_i);
      total += 5;
      if (disp_req_ready_o !== (m_q.size() < DEPTH)) begin bad++; $display("FAIL st_ready@%0d: got %b want %b", cyc, disp_req_ready_o, m_q.size() < DEPTH); end
      if (acc_req_valid_o !== (m_q.size() > 0 && m_out < MAX_OUT)) begin bad++; $display("FAIL st_valid@%0d: got %b want %b", cyc, acc_req_valid_o, m_q.size() > 0 && m_out < MAX_OUT); end
      if (outstanding_o !== OW'(m_out)) begin bad++; $display("FAIL st_out@%0d: got %0d want %0d", cyc, outstanding_o, m_out); end
      if (idle_o !== (m_q.size() == 0 && m_out == 0)) begin bad++; $display("FAIL st_idle@%0d: got %b want %b", cyc, idle_o, m_q.size() == 0 && m_out == 0); end
      if (order_err_o !== m_err) begin bad++; $display("FAIL st_err@%0d: got %b want %b", cyc, order_err_o, m_err); end
      if (m_q.size() > 0) begin
        total++;
        if (acc_req_o !== m_q[0]) begin bad++; $display("FAIL st_head@%0d: got %h want %h", cyc, acc_req_o, m_q[0]); end
      end
      if (acc_req_valid_o === 1'b1 && acc_req_ready_i) obs.push_back(acc_req_o.trans_id);
      tick();
    end
    idle_inputs();
    total++;
    if (!(m_pushed.size() == 10 && m_q.size() == 0 && m_out == 0)) begin
      bad++; $display("FAIL st_timeout: pushed %0d queued %0d outstanding %0d, want 10/0/0", m_pushed.size(), m_q.size(), m_out);
    end
    total++;
    if (obs.size() != 10) begin bad++; $display("FAIL st_issue_count: got %0d want 10", obs.size()); end
    for (int i = 0; i < obs.size() && i < 10; i++) begin
      total++;
      if (obs[i] !== trans_id_t'(i)) begin bad++; $display("FAIL st_order[%0d]: got %0d want %0d", i, obs[i], i); end
    end
  endtask

  initial begin
    idle_inputs();
    model_clear();
    test_reset();
    test_single_issue();
    test_full();
    test_outstanding_limit();
    test_reset_mid();
    test_concurrent();
    test_order();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
